// File: rtl/gelato_scoreboard.sv
// Per-warp register scoreboard with multi-port writeback release.
// Optional statistics counters: define GELATO_SCOREBOARD_STATS_EN.
module gelato_scoreboard #(
    parameter int WARP_NUM = 4,
    parameter int SB_SIZE  = 4,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 2,
    localparam int WW      = $clog2(WARP_NUM)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rdy,
    input  logic                               alloc_valid,
    input  logic [WW-1:0]                      alloc_warp,
    input  logic [REG_W-1:0]                   alloc_rd,
    output logic                               alloc_ready,
    output logic [WARP_NUM*SB_SIZE*REG_W-1:0]  regs,
    output logic [WARP_NUM-1:0]                full,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS*WW-1:0]             wb_warp,
    input  logic [WB_PORTS*REG_W-1:0]          wb_rd,
    output logic [WB_PORTS-1:0]                wb_ready,
    output logic                               err,
    output logic [31:0]                        stat_alloc_stall,
    output logic [31:0]                        stat_wb_conflict
);

    logic [REG_W-1:0]    r_tab     [WARP_NUM][SB_SIZE];
    logic [REG_W-1:0]    w_tab_nxt [WARP_NUM][SB_SIZE];
    logic [WARP_NUM-1:0] r_full;
    logic [WARP_NUM-1:0] w_full_nxt;
    logic                r_err;
    logic                w_err_set;
    logic [WB_PORTS-1:0] r_rr_ptr;
    logic [WB_PORTS-1:0] w_rr_nxt;

    logic                w_present;
    logic                w_free_found;
    int                  w_free_idx;
    logic                w_alloc_fire;

    int                  w_ptr_idx;
    int                  w_pk;
    logic                w_found;
    logic [WB_PORTS-1:0] w_rival;
    logic                w_conflict;
    logic                w_hit;

    // Allocation check against registered state only
    always_comb begin
        w_present    = 1'b0;
        w_free_found = 1'b0;
        w_free_idx   = 0;
        for (int e = 0; e < SB_SIZE; e++) begin
            if (r_tab[alloc_warp][e] == alloc_rd)
                w_present = 1'b1;
            if (!w_free_found && r_tab[alloc_warp][e] == '0) begin
                w_free_found = 1'b1;
                w_free_idx   = e;
            end
        end
        alloc_ready  = rdy && ((alloc_rd == '0) ||
                       (!r_full[alloc_warp] && !w_present));
        w_alloc_fire = alloc_valid && alloc_ready && (alloc_rd != '0);
    end

    // Per-warp round-robin arbitration among writeback ports
    always_comb begin
        w_ptr_idx  = 0;
        wb_ready   = '0;
        w_rival    = '0;
        w_conflict = 1'b0;
        w_found    = 1'b0;
        w_pk       = 0;
        w_rr_nxt   = r_rr_ptr;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (r_rr_ptr[p])
                w_ptr_idx = p;
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_ready[p] = rdy && wb_valid[p];
            for (int q = 0; q < WB_PORTS; q++) begin
                if (q != p && wb_valid[q] && wb_valid[p] &&
                    wb_warp[q*WW +: WW] == wb_warp[p*WW +: WW]) begin
                    w_rival[p] = 1'b1;
                    if (rdy)
                        w_conflict = 1'b1;
                    if (((q + WB_PORTS - w_ptr_idx) % WB_PORTS) <
                        ((p + WB_PORTS - w_ptr_idx) % WB_PORTS))
                        wb_ready[p] = 1'b0;
                end
            end
        end
        for (int k = 0; k < WB_PORTS; k++) begin
            w_pk = (w_ptr_idx + k) % WB_PORTS;
            if (!w_found && w_rival[w_pk] && wb_ready[w_pk]) begin
                w_found  = 1'b1;
                w_rr_nxt = '0;
                w_rr_nxt[(w_pk + 1) % WB_PORTS] = 1'b1;
            end
        end
    end

    // Next table: releases clear, allocation fills a slot free before them
    always_comb begin
        w_tab_nxt = r_tab;
        w_err_set = 1'b0;
        w_hit     = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            w_hit = 1'b0;
            if (wb_ready[p] && wb_rd[p*REG_W +: REG_W] != '0) begin
                for (int e = 0; e < SB_SIZE; e++) begin
                    if (!w_hit && r_tab[wb_warp[p*WW +: WW]][e] ==
                        wb_rd[p*REG_W +: REG_W]) begin
                        w_hit = 1'b1;
                        w_tab_nxt[wb_warp[p*WW +: WW]][e] = '0;
                    end
                end
                if (!w_hit)
                    w_err_set = 1'b1;
            end
        end
        if (w_alloc_fire && w_free_found)
            w_tab_nxt[alloc_warp][w_free_idx] = alloc_rd;
    end

    // Full flags derived from the next table so they register together
    always_comb begin
        w_full_nxt = '1;
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int e = 0; e < SB_SIZE; e++) begin
                if (w_tab_nxt[w][e] == '0)
                    w_full_nxt[w] = 1'b0;
            end
        end
    end

    // Scoreboard state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tab    <= '{default: '0};
            r_full   <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= {{(WB_PORTS-1){1'b0}}, 1'b1};
        end else if (rdy) begin
            r_tab  <= w_tab_nxt;
            r_full <= w_full_nxt;
            r_err  <= r_err | w_err_set;
            if (w_conflict)
                r_rr_ptr <= w_rr_nxt;
        end
    end

    // Flatten the table as [warp][entry]
    always_comb begin
        regs = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int e = 0; e < SB_SIZE; e++)
                regs[(w*SB_SIZE+e)*REG_W +: REG_W] = r_tab[w][e];
        end
    end

    assign full = r_full;
    assign err  = r_err;

`ifdef GELATO_SCOREBOARD_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_conf;

    // Saturating counters for stalled allocations and lossy writeback cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_stall <= '0;
            r_stat_conf  <= '0;
        end else if (rdy) begin
            if (alloc_valid && !alloc_ready && r_stat_stall != '1)
                r_stat_stall <= r_stat_stall + 32'd1;
            if ((wb_valid & ~wb_ready) != '0 && r_stat_conf != '1)
                r_stat_conf <= r_stat_conf + 32'd1;
        end
    end

    assign stat_alloc_stall = r_stat_stall;
    assign stat_wb_conflict = r_stat_conf;
`else
    assign stat_alloc_stall = 32'd0;
    assign stat_wb_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_gelato_scoreboard.sv
// Self-checking bench for gelato_scoreboard: directed plan then random
// traffic compared against a behavioural table model.
module tb_gelato_scoreboard;

    localparam int NW = 4;
    localparam int NE = 4;
    localparam int RW = 5;
    localparam int NP = 2;
    localparam int WW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              alloc_valid;
    logic [WW-1:0]     alloc_warp;
    logic [RW-1:0]     alloc_rd;
    logic              alloc_ready;
    logic [NW*NE*RW-1:0] regs;
    logic [NW-1:0]     full;
    logic [NP-1:0]     wb_valid;
    logic [NP*WW-1:0]  wb_warp;
    logic [NP*RW-1:0]  wb_rd;
    logic [NP-1:0]     wb_ready;
    logic              err;
    logic [31:0]       stat_alloc_stall;
    logic [31:0]       stat_wb_conflict;

    gelato_scoreboard dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rdy              (rdy),
        .alloc_valid      (alloc_valid),
        .alloc_warp       (alloc_warp),
        .alloc_rd         (alloc_rd),
        .alloc_ready      (alloc_ready),
        .regs             (regs),
        .full             (full),
        .wb_valid         (wb_valid),
        .wb_warp          (wb_warp),
        .wb_rd            (wb_rd),
        .wb_ready         (wb_ready),
        .err              (err),
        .stat_alloc_stall (stat_alloc_stall),
        .stat_wb_conflict (stat_wb_conflict)
    );

    always #5 clk = ~clk;

    int          npass = 0;
    int          nfail = 0;
    int          ntotal = 0;

    int          mtab [NW][NE];
    int          mptr;
    bit          merr;
    logic [31:0] mstall;
    logic [31:0] mconf;

    logic          c_ar;
    logic [NP-1:0] c_wbr;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW*NE*RW-1:0] mregs();
        logic [NW*NE*RW-1:0] v;
        v = '0;
        for (int w = 0; w < NW; w++)
            for (int e = 0; e < NE; e++)
                v[(w*NE+e)*RW +: RW] = RW'(mtab[w][e]);
        return v;
    endfunction

    function automatic logic [NW-1:0] mfull();
        logic [NW-1:0] f;
        for (int w = 0; w < NW; w++) begin
            f[w] = 1'b1;
            for (int e = 0; e < NE; e++)
                if (mtab[w][e] == 0) f[w] = 1'b0;
        end
        return f;
    endfunction

    function automatic logic [RW-1:0] ent(input int w, input int e);
        return regs[(w*NE+e)*RW +: RW];
    endfunction

    task automatic mreset();
        for (int w = 0; w < NW; w++)
            for (int e = 0; e < NE; e++)
                mtab[w][e] = 0;
        mptr = 0;
        merr = 0;
        mstall = 0;
        mconf = 0;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        alloc_warp  = '0;
        alloc_rd    = '0;
        wb_valid    = '0;
        wb_warp     = '0;
        wb_rd       = '0;
    endtask

    task automatic alloc(input int w, input int rd);
        idle();
        alloc_valid = 1'b1;
        alloc_warp  = WW'(w);
        alloc_rd    = RW'(rd);
    endtask

    task automatic wb(input int p, input int w, input int rd);
        wb_valid[p]         = 1'b1;
        wb_warp[p*WW +: WW] = WW'(w);
        wb_rd[p*RW +: RW]   = RW'(rd);
    endtask

    // One clock: check combinational handshakes, then registered state
    task automatic cyc();
        logic          e_ar;
        logic [NP-1:0] e_wbr;
        int            taken [NW];
        bit            contested [NW];
        int            pre [NW][NE];
        int            win, occ, p, w, rd;
        bit            present, conf, done;
        @(negedge clk);
        e_ar = 1'b0;
        if (rdy) begin
            occ = 0;
            present = 0;
            for (int i = 0; i < NE; i++) begin
                if (mtab[alloc_warp][i] != 0) occ++;
                if (mtab[alloc_warp][i] == int'(alloc_rd)) present = 1;
            end
            e_ar = (alloc_rd == 0) || (occ < NE && !present);
        end
        e_wbr = '0;
        conf = 0;
        win = -1;
        for (int i = 0; i < NW; i++) begin
            taken[i] = -1;
            contested[i] = 0;
        end
        if (rdy) begin
            for (int k = 0; k < NP; k++) begin
                p = (mptr + k) % NP;
                if (wb_valid[p]) begin
                    w = int'(wb_warp[p*WW +: WW]);
                    if (taken[w] < 0) begin
                        taken[w] = p;
                        e_wbr[p] = 1'b1;
                    end else begin
                        contested[w] = 1;
                        conf = 1;
                    end
                end
            end
            for (int k = 0; k < NP; k++) begin
                p = (mptr + k) % NP;
                if (win < 0 && e_wbr[p] &&
                    contested[int'(wb_warp[p*WW +: WW])])
                    win = p;
            end
        end
        if (rst_n) begin
            check("alloc_ready", 128'(alloc_ready), 128'(e_ar));
            check("wb_ready", 128'(wb_ready), 128'(e_wbr));
        end
        c_ar  = alloc_ready;
        c_wbr = wb_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mreset();
        end else if (rdy) begin
            pre = mtab;
            for (int q = 0; q < NP; q++) begin
                w  = int'(wb_warp[q*WW +: WW]);
                rd = int'(wb_rd[q*RW +: RW]);
                if (e_wbr[q] && rd != 0) begin
                    done = 0;
                    for (int e = 0; e < NE; e++)
                        if (!done && mtab[w][e] == rd) begin
                            mtab[w][e] = 0;
                            done = 1;
                        end
                    if (!done) merr = 1;
                end
            end
            if (alloc_valid && e_ar && alloc_rd != 0) begin
                done = 0;
                for (int e = 0; e < NE; e++)
                    if (!done && pre[alloc_warp][e] == 0) begin
                        mtab[alloc_warp][e] = int'(alloc_rd);
                        done = 1;
                    end
            end
            if (conf) mptr = (win + 1) % NP;
            if (alloc_valid && !e_ar && mstall != '1) mstall++;
            if (conf && mconf != '1) mconf++;
        end
        check("regs", 128'(regs), 128'(mregs()));
        check("full", 128'(full), 128'(mfull()));
        check("err", 128'(err), 128'(merr));
`ifdef GELATO_SCOREBOARD_STATS_EN
        check("stat_alloc_stall", 128'(stat_alloc_stall), 128'(mstall));
        check("stat_wb_conflict", 128'(stat_wb_conflict), 128'(mconf));
`else
        check("stat_alloc_stall", 128'(stat_alloc_stall), 128'(0));
        check("stat_wb_conflict", 128'(stat_wb_conflict), 128'(0));
`endif
    endtask

    logic [NW*NE*RW-1:0] snap;
    int                  rw;

    initial begin
        mreset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        cyc();
        cyc();
        check("reset_regs", 128'(regs), 128'(0));
        check("reset_err", 128'(err), 128'(0));
        rst_n = 1'b1;

        alloc(1, 5); cyc(); check("alloc_rd5", 128'(c_ar), 128'(1));
        alloc(1, 6); cyc(); check("alloc_rd6", 128'(c_ar), 128'(1));
        alloc(1, 7); cyc(); check("alloc_rd7", 128'(c_ar), 128'(1));
        alloc(1, 8); cyc(); check("alloc_rd8", 128'(c_ar), 128'(1));
        check("full1_set", 128'(full[1]), 128'(1));
        alloc(1, 9); cyc(); check("alloc_full", 128'(c_ar), 128'(0));

        idle(); wb(0, 1, 6); cyc();
        check("wb_w1_rd6", 128'(c_wbr), 128'(2'b01));
        check("entry1_clear", 128'(ent(1, 1)), 128'(0));
        check("full1_clear", 128'(full[1]), 128'(0));
        alloc(1, 9); cyc();
        check("entry1_rd9", 128'(ent(1, 1)), 128'(9));

        alloc(2, 3); cyc();
        alloc(2, 3); cyc(); check("alloc_dup", 128'(c_ar), 128'(0));
        snap = regs;
        alloc(2, 0); cyc(); check("alloc_rd0", 128'(c_ar), 128'(1));
        check("rd0_nochange", 128'(regs), 128'(snap));

        alloc(0, 4); cyc();
        alloc(0, 5); cyc();
        alloc(0, 10); cyc();
        alloc(3, 7); cyc();
        idle(); wb(0, 0, 4); wb(1, 0, 5); cyc();
        check("conflict_1", 128'(c_wbr), 128'(2'b01));
        cyc();
        check("conflict_2", 128'(c_wbr), 128'(2'b10));
        idle(); wb(0, 0, 10); wb(1, 3, 7); cyc();
        check("two_warps", 128'(c_wbr), 128'(2'b11));
        check("w0_e2_clear", 128'(ent(0, 2)), 128'(0));
        check("w3_e0_clear", 128'(ent(3, 0)), 128'(0));
        idle(); wb(0, 0, 0); wb(1, 0, 0); cyc();
        check("ptr_kept", 128'(c_wbr), 128'(2'b01));

        idle(); wb(0, 0, 12); cyc();
        check("err_set", 128'(err), 128'(1));
        idle(); cyc();
        check("err_sticky", 128'(err), 128'(1));
        rst_n = 1'b0; cyc();
        check("midrst_regs", 128'(regs), 128'(0));
        check("midrst_err", 128'(err), 128'(0));
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            alloc(2, i); cyc();
        end
        for (int i = 0; i < 3; i++) begin
            alloc(2, 9); cyc();
        end
`ifdef GELATO_SCOREBOARD_STATS_EN
        check("stall_3", 128'(stat_alloc_stall), 128'(3));
`endif
        idle(); rdy = 1'b0; wb(0, 2, 1); cyc();
        check("rdy0_wb", 128'(c_wbr), 128'(0));
        check("rdy0_hold", 128'(ent(2, 0)), 128'(1));
        rdy = 1'b1;

        for (int i = 0; i < 500; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            rdy         = ($urandom_range(0, 9) != 0);
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_warp  = WW'($urandom_range(0, NW - 1));
            alloc_rd    = RW'($urandom_range(0, 9));
            for (int p = 0; p < NP; p++) begin
                wb_valid[p] = 1'($urandom_range(0, 1));
                rw = $urandom_range(0, NW - 1);
                wb_warp[p*WW +: WW] = WW'(rw);
                if ($urandom_range(0, 9) < 7)
                    wb_rd[p*RW +: RW] =
                        RW'(mtab[rw][$urandom_range(0, NE - 1)]);
                else
                    wb_rd[p*RW +: RW] = RW'($urandom_range(0, 15));
            end
            cyc();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/gelato_scoreboard.md
Name: gelato_scoreboard

Overview:
- Per-warp register scoreboard: tracks destination registers of issued, not-yet-written-back instructions.
- Allocates an entry when the warp scheduler issues an instruction.
- Releases entries on writeback from multiple execution units, arbitrating conflicting releases.
- Drives the dirty-register table and per-warp full flags that the warp scheduler uses for hazard and issue decisions.

Parameters:
- WARP_NUM, 4, number of warps; WW = $clog2(WARP_NUM).
- SB_SIZE, 4, scoreboard entries per warp.
- REG_W, 5, register-number width; register 0 means "no destination" / free entry.
- WB_PORTS, 2, number of writeback (release) ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rdy  in  1  global enable; state frozen when 0.
- alloc_valid  in  1  scheduler issues an instruction.
- alloc_warp  in  WW  issuing warp.
- alloc_rd  in  REG_W  destination register.
- alloc_ready  out  1  allocation accepted this cycle (combinational).
- regs  out  WARP_NUM*SB_SIZE*REG_W  dirty table, flattened as [warp][entry]; 0 = free.
- full  out  WARP_NUM  all entries of the warp are occupied.
- wb_valid  in  WB_PORTS  release request per port.
- wb_warp  in  WB_PORTS*WW  warp per port.
- wb_rd  in  WB_PORTS*REG_W  register per port.
- wb_ready  out  WB_PORTS  release accepted (combinational).
- err  out  1  sticky: release of a non-dirty register.
- stat_alloc_stall  out  32  allocation stall counter (see Optional Feature).
- stat_wb_conflict  out  32  writeback conflict counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge): all entries 0, err=0, rr_ptr=0, counters 0. A mid-operation reset discards all pending entries.
- rdy=0: no state change; alloc_ready=0 and wb_ready=0.
- regs and full are registered; every update is visible 1 cycle after acceptance.
- Allocation, evaluated on registered state (the current cycle's releases are not visible):
  - alloc_rd==0: alloc_ready=1, no entry written.
  - Otherwise alloc_ready=1 iff the warp is not full and alloc_rd is not already present in that warp.
  - An accepted allocation writes the lowest-index free entry.
- Release arbitration:
  - Two ports conflict if they target the same warp.
  - rr_ptr (WB_PORTS-wide one-hot round-robin pointer) picks the highest-priority port.
  - Per warp, only the highest-priority valid port gets wb_ready=1; the others stall.
  - rr_ptr rotates to the port after the winner only in cycles where a conflict occurred.
  - Non-conflicting ports targeting different warps are all accepted in the same cycle.
- Accepted release clears the lowest-index entry of that warp equal to wb_rd.
  - No match: nothing cleared, err set sticky.
  - wb_rd==0: accepted as a no-op, no err.
- Same-cycle allocation and release on the same warp:
  - The release clears its entry; the allocation takes the lowest entry that was free in registered state.
  - A release never frees an entry the same-cycle allocation then reuses.
- alloc_rd equal to a register being released that same cycle: alloc_ready=0 (still present in registered state); succeeds the next cycle.

Optional Feature:
- Macro: GELATO_SCOREBOARD_STATS_EN.
- Defined:
  - stat_alloc_stall increments each rdy cycle with alloc_valid=1 and alloc_ready=0.
  - stat_wb_conflict increments once per cycle in which at least one wb_valid port receives wb_ready=0.
  - Both counters saturate at 2^32-1 and are cleared by reset.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset, then alloc warp 1 rd 5, 6, 7, 8 on consecutive cycles -> each alloc_ready=1; full[1]=1 one cycle after the 4th; a 5th alloc of rd 9 gives alloc_ready=0.
- Warp 1 full; wb port0 warp 1 rd 6 -> wb_ready[0]=1; next cycle entry 1=0, full[1]=0; alloc rd 9 lands in entry 1.
- Warp 2 rd 3 dirty; alloc warp 2 rd 3 -> alloc_ready=0; alloc rd 0 -> alloc_ready=1, table unchanged.
- Both wb ports target warp 0 (rd 4, rd 5) with rr_ptr=port0 -> wb_ready=2'b01; next cycle a repeat gives wb_ready=2'b10.
- Ports target warps 0 and 3 together -> wb_ready=2'b11, both entries cleared, rr_ptr unchanged.
- Release warp 0 rd 12 that is not dirty -> err=1 and stays 1; assert rst_n=0 mid-sequence -> all regs 0, err=0. With GELATO_SCOREBOARD_STATS_EN defined, three stalled allocs give stat_alloc_stall=3.
